psi_stream_accum: RTL and testbench

PSI_STREAM_ACCUM -- requirements
Module: psi_stream_accum

---
 rtl/psi_stream_accum.sv | 157 +++++++++++++++
 tb/tb_psi_stream_accum.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/psi_stream_accum.sv
// Streaming set-intersection / set-union accumulator over N party bitmaps.
// Each party supplies K = B/W words; the combined bitmap and its popcount are presented on a valid/ready output.
module psi_stream_accum #(
    parameter int B = 16,
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mode,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [B-1:0]               o,
    output logic [$clog2(B+1)-1:0]     o_count
);

    // state | meaning
    // IDLE  | waiting for the first beat of a run
    // LOAD  | collecting words, accumulator partially built
    // DONE  | result presented, waiting for the output handshake

    localparam int K  = B / W;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(B + 1);

    localparam logic [KW-1:0] WORD_LAST  = KW'(K - 1);
    localparam logic [PW-1:0] PARTY_LAST = PW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            ready_q;
    logic            mode_q;
    logic [KW-1:0]   word_q;
    logic [PW-1:0]   party_q;
    logic [B-1:0]    acc_q;
    logic [B-1:0]    acc_next;
    logic [B-1:0]    o_q;
    logic [CW-1:0]   cnt_q;
    logic            accept;
    logic            last_beat;

    function automatic logic [CW-1:0] popcount(input logic [B-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < B; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // ready_q keeps in_ready low until the first edge after reset release
    assign in_ready  = ready_q && (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign o         = o_q;
    assign o_count   = cnt_q;

    // a beat coinciding with flush is discarded
    assign accept    = in_valid && in_ready && !flush;
    assign last_beat = (party_q == PARTY_LAST) && (word_q == WORD_LAST);

    always_comb begin
        acc_next = acc_q;
        for (int j = 0; j < K; j++) begin
            if (KW'(j) == word_q) begin
                if (party_q == '0) begin
                    acc_next[j*W +: W] = in_data;
                end else if (mode_q) begin
                    acc_next[j*W +: W] = acc_q[j*W +: W] | in_data;
                end else begin
                    acc_next[j*W +: W] = acc_q[j*W +: W] & in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            mode_q  <= 1'b0;
            word_q  <= '0;
            party_q <= '0;
            acc_q   <= '0;
            o_q     <= '0;
            cnt_q   <= '0;
        end else begin
            ready_q <= 1'b1;
            if (flush) begin
                word_q  <= '0;
                party_q <= '0;
            end else if (accept) begin
                acc_q <= acc_next;
                if (state_q == IDLE) begin
                    mode_q <= mode;
                end
                if (last_beat) begin
                    word_q  <= '0;
                    party_q <= '0;
                    o_q     <= acc_next;
                    cnt_q   <= popcount(acc_next);
                end else if (word_q == WORD_LAST) begin
                    word_q  <= '0;
                    party_q <= party_q + 1'b1;
                end else begin
                    word_q <= word_q + 1'b1;
                end
            end else if (state_q == DONE && out_ready) begin
                word_q  <= '0;
                party_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_psi_stream_accum.sv
// Directed bench for psi_stream_accum: a 2-party and a 3-party instance driven
// with hand-computed vectors, covering backpressure, flush and async reset.
module tb_psi_stream_accum;

    logic        clk;
    logic        rst_n;

    logic        mode2, flush2, in_valid2, out_ready2;
    logic        in_ready2, out_valid2;
    logic [7:0]  in_data2;
    logic [15:0] o2;
    logic [4:0]  o_count2;

    logic        mode3, flush3, in_valid3, out_ready3;
    logic        in_ready3, out_valid3;
    logic [7:0]  in_data3;
    logic [15:0] o3;
    logic [4:0]  o_count3;

    int n_checks;
    int n_pass;

    psi_stream_accum #(.B(16), .N(2), .W(8)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode2),
        .flush     (flush2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .o         (o2),
        .o_count   (o_count2)
    );

    psi_stream_accum #(.B(16), .N(3), .W(8)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode3),
        .flush     (flush3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .o         (o3),
        .o_count   (o_count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // four beats into the 2-party instance; mode flips after the first beat
    // to confirm it is sampled only once; gap cycles carry junk data with in_valid low
    task automatic send2(input logic md, input int gap,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] beats [4];
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        mode2 = md;
        for (int i = 0; i < 4; i++) begin
            in_valid2 = 1'b1;
            in_data2  = beats[i];
            if (i == 3) check("no_early_valid", 32'(out_valid2), 32'd0);
            step();
            mode2 = ~md;
            in_valid2 = 1'b0;
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    in_data2 = 8'h5A ^ 8'(g);
                    step();
                end
            end
        end
    endtask

    task automatic handshake2();
        out_ready2 = 1'b1;
        step();
        out_ready2 = 1'b0;
    endtask

    initial begin
        logic [7:0] b3v [6];
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        {mode2, flush2, in_valid2, out_ready2} = '0;
        {mode3, flush3, in_valid3, out_ready3} = '0;
        in_data2 = '0;
        in_data3 = '0;

        #2;
        check("rst_in_ready",  32'(in_ready2),  32'd0);
        check("rst_out_valid", 32'(out_valid2), 32'd0);
        check("rst_o",         32'(o2),         32'd0);
        check("rst_o_count",   32'(o_count2),   32'd0);
        #10;
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 32'(in_ready2), 32'd1);

        // intersection
        send2(1'b0, 0, 8'hF0, 8'hF0, 8'h00, 8'hFF);
        check("and_valid", 32'(out_valid2), 32'd1);
        check("and_o",     32'(o2),         32'hF000);
        check("and_cnt",   32'(o_count2),   32'd4);

        // backpressure with a beat offered that must not be taken
        in_valid2 = 1'b1;
        in_data2  = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_o",     32'(o2),         32'hF000);
            check("bp_cnt",   32'(o_count2),   32'd4);
            check("bp_ready", 32'(in_ready2),  32'd0);
            check("bp_valid", 32'(out_valid2), 32'd1);
        end
        in_valid2 = 1'b0;
        handshake2();
        check("hs_valid", 32'(out_valid2), 32'd0);
        check("hs_ready", 32'(in_ready2),  32'd1);

        // union, with gaps carrying junk data
        send2(1'b1, 1, 8'hF0, 8'hF0, 8'h00, 8'hFF);
        check("or_valid", 32'(out_valid2), 32'd1);
        check("or_o",     32'(o2),         32'hFFF0);
        check("or_cnt",   32'(o_count2),   32'd12);
        handshake2();

        // flush after two beats, concurrent beat discarded
        send2_partial();
        flush2    = 1'b1;
        in_valid2 = 1'b1;
        in_data2  = 8'hAA;
        step();
        flush2    = 1'b0;
        in_valid2 = 1'b0;
        check("fl_valid", 32'(out_valid2), 32'd0);
        check("fl_ready", 32'(in_ready2),  32'd1);
        send2(1'b0, 0, 8'h0F, 8'hF0, 8'hFF, 8'hFF);
        check("fl_run_valid", 32'(out_valid2), 32'd1);
        check("fl_run_o",     32'(o2),         32'hF00F);
        check("fl_run_cnt",   32'(o_count2),   32'd8);
        handshake2();

        // 3-party instance
        b3v[0] = 8'hFF; b3v[1] = 8'hFF; b3v[2] = 8'h0F;
        b3v[3] = 8'hF0; b3v[4] = 8'h3C; b3v[5] = 8'h3C;
        mode3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid3 = 1'b1;
            in_data3  = b3v[i];
            step();
        end
        in_valid3 = 1'b0;
        check("n3_valid", 32'(out_valid3), 32'd1);
        check("n3_o",     32'(o3),         32'h300C);
        check("n3_cnt",   32'(o_count3),   32'd4);
        out_ready3 = 1'b1;
        step();
        out_ready3 = 1'b0;
        check("n3_hs_valid", 32'(out_valid3), 32'd0);

        // async reset mid-LOAD with in_valid held high
        mode2     = 1'b0;
        in_valid2 = 1'b1;
        in_data2  = 8'hFF;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_ready", 32'(in_ready2),  32'd0);
        check("ar_valid", 32'(out_valid2), 32'd0);
        check("ar_o",     32'(o2),         32'd0);
        #10;
        in_valid2 = 1'b0;
        rst_n = 1'b1;
        step();
        check("ar_post_ready", 32'(in_ready2), 32'd1);
        send2(1'b1, 0, 8'h01, 8'h80, 8'h10, 8'h08);
        check("ar_run_o",   32'(o2),       32'h8811);
        check("ar_run_cnt", 32'(o_count2), 32'd4);

        // flush in DONE drops the result
        flush2 = 1'b1;
        step();
        flush2 = 1'b0;
        check("fd_valid", 32'(out_valid2), 32'd0);
        check("fd_ready", 32'(in_ready2),  32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // two pre-flush beats that would corrupt the next run if retained
    task automatic send2_partial();
        mode2     = 1'b1;
        in_valid2 = 1'b1;
        in_data2  = 8'h00;
        step();
        in_data2  = 8'h00;
        step();
        in_valid2 = 1'b0;
    endtask

endmodule
